// File: rtl/booth_controller.sv
// booth_controller: sequencing FSM for a radix-2 Booth multiplier datapath.
// Accepts operands, runs WIDTH_IN add/sub/shift steps, then holds the product.
module booth_controller #(
    parameter int WIDTH_IN = 16,
    parameter int CNT_W    = $clog2(WIDTH_IN) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    input  logic [1:0]       pp_lsb,
    output logic             ld,
    output logic             ld_m,
    output logic             ld_p,
    output logic             en,
    output logic [1:0]       alu_op,
    output logic             busy,
    output logic [CNT_W-1:0] iter,
    output logic             out_valid,
    input  logic             out_ready
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] ALU_NOP = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH_IN - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH_IN);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        in_ready  = 1'b0;
        ld        = 1'b0;
        ld_m      = 1'b0;
        ld_p      = 1'b0;
        en        = 1'b0;
        alu_op    = ALU_NOP;
        busy      = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = ~abort;
                if (in_valid && !abort) begin
                    ld      = 1'b1;
                    ld_m    = 1'b1;
                    iter_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                en   = 1'b1;
                // {Q0, Q-1}: 0->1 transition adds M, 1->0 subtracts M
                unique case (1'b1)
                    (pp_lsb == 2'b01): alu_op = ALU_ADD;
                    (pp_lsb == 2'b10): alu_op = ALU_SUB;
                    default:           alu_op = ALU_NOP;
                endcase
                if (iter_q != FULL) begin
                    iter_d = iter_q + 1'b1;
                end
                if (iter_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    iter_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                iter_d  = '0;
                state_d = IDLE;
            end
        endcase

        // A product discarded by abort must never appear valid.
        if (abort) begin
            ld        = 1'b0;
            ld_m      = 1'b0;
            en        = 1'b0;
            out_valid = 1'b0;
            ld_p      = 1'b1;
            iter_d    = '0;
            state_d   = IDLE;
        end
    end

    assign iter = iter_q;

endmodule

// File: tb/tb_booth_controller.sv
// tb_booth_controller: directed bench with a datapath model and a cycle-level
// behavioural model of the controller handshakes, latency and Booth recoding.
module tb_booth_controller;
    localparam int W  = 16;
    localparam int CW = $clog2(W) + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic abort = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, ld, ld_m, ld_p, en, busy, out_valid;
    logic [1:0] alu_op, pp_lsb;
    logic [CW-1:0] iter;

    logic [15:0] opA = '0;
    logic [15:0] opB = '0;
    logic [15:0] M = '0;
    logic [15:0] acc;
    logic [32:0] P = '0;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_add = 0;
    int n_sub = 0;
    logic [1:0] seq [4];
    bit chk_on = 1'b0;

    int m_k = -1;
    bit m_done = 1'b0;

    booth_controller #(.WIDTH_IN(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .abort(abort), .pp_lsb(pp_lsb),
        .ld(ld), .ld_m(ld_m), .ld_p(ld_p), .en(en),
        .alu_op(alu_op), .busy(busy), .iter(iter),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Booth datapath: P = {acc[15:0], Q[15:0], Q-1}
    assign pp_lsb = P[1:0];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            P <= '0;
        end else if (ld_p) begin
            P <= '0;
        end else if (ld) begin
            P <= {16'b0, opB, 1'b0};
        end else if (en) begin
            acc = P[32:17];
            if (alu_op == 2'b01) acc = acc + M;
            else if (alu_op == 2'b10) acc = acc - M;
            P <= {acc[15], acc, P[16:1]};
        end
        if (reset && ld_m) M <= opA;
    end

    always @(negedge clk) begin
        if (en) begin
            if (alu_op == 2'b01) n_add++;
            else if (alu_op == 2'b10) n_sub++;
            if (iter < 4) seq[iter[1:0]] = alu_op;
        end
    end

    // Behavioural model: idle / running step k / holding product.
    always @(negedge clk) begin
        logic [13:0] got, exp;
        bit e_ir, e_ld, e_en, e_busy, e_ov;
        logic [1:0] e_op;
        int e_it, d;
        if (chk_on) begin
            if (!reset) begin
                m_k = -1;
                m_done = 1'b0;
            end
            e_ir = 0; e_ld = 0; e_en = 0; e_busy = 0; e_ov = 0;
            e_op = 2'b00; e_it = 0;
            if (m_done) begin
                e_ov = !abort;
                e_it = W;
                if (abort || out_ready) m_done = 1'b0;
            end else if (m_k >= 0) begin
                e_busy = 1;
                e_it = m_k;
                e_en = !abort;
                d = int'(pp_lsb[0]) - int'(pp_lsb[1]);
                case (d)
                    1:       e_op = 2'b01;
                    -1:      e_op = 2'b10;
                    default: e_op = 2'b00;
                endcase
                if (abort) m_k = -1;
                else if (m_k == W - 1) begin
                    m_k = -1;
                    m_done = 1'b1;
                end else m_k++;
            end else begin
                e_ir = !abort;
                e_ld = in_valid && !abort;
                if (e_ld && reset) m_k = 0;
            end
            exp = {e_ir, e_ld, e_ld, abort, e_en, e_op, e_busy, e_ov, CW'(e_it)};
            got = {in_ready, ld, ld_m, ld_p, en, alu_op, busy, out_valid, iter};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL cycle %0d: outputs got %b expected %b", cyc, got, exp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input int prod, input int nadd, input int nsub,
                         input string tag);
        int t0, tov;
        opA = a; opB = b;
        n_add = 0; n_sub = 0;
        in_valid = 1'b1;
        #1;
        check({tag, "_accept"}, {29'b0, in_ready, ld, ld_m}, 32'd7);
        t0 = cyc;
        tick();
        in_valid = 1'b0;
        tov = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (out_valid) begin
                tov = cyc;
                break;
            end
            tick();
        end
        check({tag, "_latency"}, 32'(tov - t0), 32'(W + 1));
        check({tag, "_product"}, P[32:1], 32'(prod));
        check({tag, "_adds"}, 32'(n_add), 32'(nadd));
        check({tag, "_subs"}, 32'(n_sub), 32'(nsub));
        check({tag, "_iter"}, 32'(iter), 32'(W));
    endtask

    initial begin
        chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("t1_reset_outs",
              {18'b0, in_ready, ld, ld_m, ld_p, en, alu_op, busy, out_valid, iter},
              32'b10_0000_0000_0000);

        tick();
        do_op(16'd3, 16'd5, 15, 2, 2, "t2");
        check("t2_seq", {24'b0, seq[0], seq[1], seq[2], seq[3]}, 32'b1001_1001);
        tick();

        do_op(16'hFFF9, 16'h8000, 229376, 0, 1, "t3");
        tick();

        out_ready = 1'b0;
        do_op(16'd100, 16'hFFFD, -300, 1, 2, "t4a");
        in_valid = 1'b1;
        opA = 16'd6;
        opB = 16'd7;
        for (int i = 0; i < 5; i++) begin
            check("t4_stall", {28'b0, out_valid, en, in_ready, ld}, 32'b1000);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("t4_release", {30'b0, out_valid, in_ready}, 32'b10);
        tick();
        do_op(16'd6, 16'd7, 42, 1, 1, "t4b");
        tick();

        opA = 16'd9; opB = 16'd9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 40 && iter != CW'(7); i++) tick();
        check("t5_at7", 32'(iter), 32'd7);
        abort = 1'b1;
        #1;
        check("t5_abort_pulse", {28'b0, ld_p, en, ld, busy}, 32'b1001);
        tick();
        in_valid = 1'b1;
        #1;
        check("t5_iter0", 32'(iter), 32'd0);
        check("t5_no_accept", {28'b0, busy, in_ready, ld, ld_p}, 32'b0001);
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        #1;
        check("t5_idle", {30'b0, busy, out_valid}, 32'b0);
        repeat (20) tick();

        opA = 16'd11; opB = 16'd13;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 40 && iter != CW'(10); i++) tick();
        check("t6_at10", 32'(iter), 32'd10);
        reset = 1'b0;
        #1;
        check("t6_async_iter", 32'(iter), 32'd0);
        check("t6_async_outs", {27'b0, busy, ld_p, in_ready, out_valid, en}, 32'b00100);
        tick();
        tick();
        reset = 1'b1;
        tick();
        do_op(16'd2, 16'd2, 4, 1, 1, "t6");
        tick();

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
